config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 110 +++++++++++
 tb/tb_config_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Serial configuration loader: streams WORD_W-bit words MSB-first into two CHAIN_LEN-bit
// configuration chains, dropping the unused LSBs of the final partial word.
module config_loader #(
  parameter int CHAIN_LEN = 30,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] word_a,
  input  logic [WORD_W-1:0] word_b,
  output logic              cfg_en,
  output logic              cfg_out_a,
  output logic              cfg_out_b,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int BITS_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_WORD = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BITS_W-1:0] bits_left;
  logic [WORD_W-1:0] shreg_a;
  logic [WORD_W-1:0] shreg_b;
  logic              in_shift;
  logic              handshake;

  // Number of bits of the next word that still fit in the chain.
  function automatic logic [BITS_W-1:0] word_bits(input logic [CNT_W-1:0] cnt);
    int remaining;
    remaining = CHAIN_LEN - int'(cnt);
    if (remaining > WORD_W)
      return BITS_W'(WORD_W);
    return BITS_W'(remaining);
  endfunction

  assign in_shift   = (state == SHIFT);
  assign word_ready = (state == WAIT_WORD) && !abort;
  assign handshake  = word_ready && word_valid;
  assign cfg_en     = in_shift && !abort;
  assign cfg_out_a  = in_shift && shreg_a[WORD_W-1];
  assign cfg_out_b  = in_shift && shreg_b[WORD_W-1];
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bits_left <= '0;
      shreg_a   <= '0;
      shreg_b   <= '0;
      aborted   <= 1'b0;
    end else begin
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT_WORD;
            bit_cnt <= '0;
          end
        end
        WAIT_WORD: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (handshake) begin
            shreg_a   <= word_a;
            shreg_b   <= word_b;
            bits_left <= word_bits(bit_cnt);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else begin
            shreg_a   <= shreg_a << 1;
            shreg_b   <= shreg_b << 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            bits_left <= bits_left - BITS_W'(1);
            // Last bit of this word: the chain is full once bit_cnt reaches CHAIN_LEN.
            if (bits_left == BITS_W'(1))
              state <= (bit_cnt == LAST_CNT) ? DONE : WAIT_WORD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Randomized self-checking bench for config_loader against a word-concatenation model
// of the expected chain stream.
module tb_config_loader;

  localparam int CHAIN_LEN = 30;
  localparam int WORD_W    = 8;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int TOT       = NWORDS * WORD_W;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic [WORD_W-1:0] word_a = '0;
  logic [WORD_W-1:0] word_b = '0;
  logic              cfg_en;
  logic              cfg_out_a;
  logic              cfg_out_b;
  logic              busy;
  logic              done;
  logic              aborted;

  int n_cmp = 0;
  int n_bad = 0;

  int en_cnt = 0;
  int done_cnt = 0;
  int ab_cnt = 0;
  logic [CHAIN_LEN-1:0] chain_a = '0;
  logic [CHAIN_LEN-1:0] chain_b = '0;

  config_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .abort(abort),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_a(word_a),
    .word_b(word_b),
    .cfg_en(cfg_en),
    .cfg_out_a(cfg_out_a),
    .cfg_out_b(cfg_out_b),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Behaves like the downstream chains: shift in whenever cfg_en is high.
  always @(negedge clk) begin
    if (cfg_en) begin
      chain_a <= {chain_a[CHAIN_LEN-2:0], cfg_out_a};
      chain_b <= {chain_b[CHAIN_LEN-2:0], cfg_out_b};
      en_cnt  <= en_cnt + 1;
    end
    if (done)    done_cnt <= done_cnt + 1;
    if (aborted) ab_cnt   <= ab_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_abort(input int exp_en, input int done0, input int ab0);
    @(negedge clk);
    check_val("abort_pulse", aborted, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_idle_en", cfg_en, 0);
    tick();
    @(negedge clk);
    check_val("abort_pulse_len", aborted, 0);
    tick();
    check_val("abort_en_count", en_cnt, exp_en);
    check_val("abort_done_count", done_cnt - done0, 0);
    check_val("abort_count", ab_cnt - ab0, 1);
  endtask

  // ab_word < 0: no abort; ab_bit < 0: abort while word ab_word is offered in WAIT_WORD,
  // else abort in shift cycle ab_bit of that word. stall_word gets exactly 5 stall cycles.
  task automatic run_load(input int stall_max, input int stall_word, input int ab_word,
                          input int ab_bit, input bit last_ff);
    logic [WORD_W-1:0] wa [NWORDS];
    logic [WORD_W-1:0] wb [NWORDS];
    logic [TOT-1:0] cat_a;
    logic [TOT-1:0] cat_b;
    logic [TOT-1:0] exp_a;
    logic [TOT-1:0] exp_b;
    int en0, done0, ab0, pos, nb, stall;
    cat_a = '0;
    cat_b = '0;
    for (int i = 0; i < NWORDS; i++) begin
      wa[i] = WORD_W'($urandom);
      wb[i] = WORD_W'($urandom);
      if (last_ff && i == NWORDS - 1) wa[i] = '1;
      cat_a = (cat_a << WORD_W) | TOT'(wa[i]);
      cat_b = (cat_b << WORD_W) | TOT'(wb[i]);
    end
    en0 = en_cnt;
    done0 = done_cnt;
    ab0 = ab_cnt;
    pos = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < NWORDS; w++) begin
      stall = (w == stall_word) ? 5 : int'($urandom_range(0, stall_max));
      start = 1'b0;
      word_valid = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check_val("stall_en", cfg_en, 0);
        check_val("stall_ready", word_ready, 1);
        tick();
      end
      word_a = wa[w];
      word_b = wb[w];
      word_valid = 1'b1;
      if (w == ab_word && ab_bit < 0) begin
        abort = 1'b1;
        @(negedge clk);
        check_val("abort_wait_ready", word_ready, 0);
        check_val("abort_wait_en", cfg_en, 0);
        tick();
        abort = 1'b0;
        word_valid = 1'b0;
        finish_abort(en0 + pos, done0, ab0);
        return;
      end
      @(negedge clk);
      check_val("hs_ready", word_ready, 1);
      tick();
      nb = (CHAIN_LEN - pos < WORD_W) ? CHAIN_LEN - pos : WORD_W;
      for (int b = 0; b < nb; b++) begin
        word_valid = 1'($urandom_range(0, 1));
        word_a = WORD_W'($urandom);
        word_b = WORD_W'($urandom);
        start = 1'($urandom_range(0, 1));
        if (w == ab_word && b == ab_bit) begin
          start = 1'b0;
          abort = 1'b1;
          @(negedge clk);
          check_val("abort_shift_en", cfg_en, 0);
          tick();
          abort = 1'b0;
          word_valid = 1'b0;
          finish_abort(en0 + pos, done0, ab0);
          return;
        end
        @(negedge clk);
        check_val("shift_en", cfg_en, 1);
        check_val("shift_ready", word_ready, 0);
        check_val("bit_a", cfg_out_a, wa[w][WORD_W-1-b]);
        check_val("bit_b", cfg_out_b, wb[w][WORD_W-1-b]);
        tick();
        pos++;
      end
    end
    start = 1'b0;
    word_valid = 1'b0;
    abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_val("done_pulse", done, 1);
    check_val("done_busy", busy, 1);
    check_val("done_en", cfg_en, 0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check_val("done_len", done, 0);
    check_val("idle_busy", busy, 0);
    check_val("done_no_aborted", aborted, 0);
    tick();
    exp_a = cat_a >> (TOT - CHAIN_LEN);
    exp_b = cat_b >> (TOT - CHAIN_LEN);
    check_val("en_count", en_cnt - en0, CHAIN_LEN);
    check_val("done_count", done_cnt - done0, 1);
    check_val("aborted_count", ab_cnt - ab0, 0);
    check_val("chain_a", 32'(chain_a), 32'(exp_a[CHAIN_LEN-1:0]));
    check_val("chain_b", 32'(chain_b), 32'(exp_b[CHAIN_LEN-1:0]));
  endtask

  task automatic reset_mid_load();
    int done0, ab0;
    done0 = done_cnt;
    ab0 = ab_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    word_a = WORD_W'($urandom);
    word_b = WORD_W'($urandom);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    tick();
    #2 nrst = 1'b0;
    #1;
    check_val("rst_en", cfg_en, 0);
    check_val("rst_out_a", cfg_out_a, 0);
    check_val("rst_out_b", cfg_out_b, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", word_ready, 0);
    check_val("rst_done", done, 0);
    check_val("rst_aborted", aborted, 0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    @(negedge clk);
    check_val("post_rst_busy", busy, 0);
    tick();
    check_val("rst_done_count", done_cnt - done0, 0);
    check_val("rst_abort_count", ab_cnt - ab0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_val("reset_en", cfg_en, 0);
    check_val("reset_out_a", cfg_out_a, 0);
    check_val("reset_out_b", cfg_out_b, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_aborted", aborted, 0);
    check_val("reset_ready", word_ready, 0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    abort = 1'b1;
    word_valid = 1'b1;
    @(negedge clk);
    check_val("idle_ready", word_ready, 0);
    check_val("idle_busy0", busy, 0);
    tick();
    abort = 1'b0;
    word_valid = 1'b0;
    @(negedge clk);
    check_val("idle_abort_ignored", aborted, 0);
    check_val("idle_busy1", busy, 0);
    tick();

    run_load(0, -1, -1, 0, 1'b0);
    run_load(0, -1, -1, 0, 1'b1);
    run_load(0, 2, -1, 0, 1'b0);
    run_load(0, -1, 1, 2, 1'b0);
    run_load(0, -1, 2, -1, 1'b0);
    run_load(0, -1, -1, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      int aw;
      int ab;
      if ($urandom_range(0, 2) == 0) begin
        aw = int'($urandom_range(0, NWORDS - 1));
        ab = int'($urandom_range(0, 6)) - 1;
      end else begin
        aw = -1;
        ab = 0;
      end
      run_load(3, -1, aw, ab, 1'($urandom_range(0, 1)));
    end

    reset_mid_load();
    run_load(2, -1, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
